// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide that take WIDTH+1 cycles.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              done_q, done_d;
    // hi/lo hold {accumulator upper, multiplier} for MUL and {remainder, quotient} for DIV
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [3:0]        op_q, op_d;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH-1:0]  rem_sub;
    logic              rem_ge;

    // Covers every op that completes in one cycle, including divide by zero.
    function automatic logic [WIDTH-1:0] single_op(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = (sa < sb) ? WIDTH'(1) : '0;
            OP_SLTU: r = (a < b) ? WIDTH'(1) : '0;
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SRL:  r = a >> b[SHW-1:0];
            OP_SRA:  r = sa >>> b[SHW-1:0];
            OP_DIVU: r = '1;
            OP_REMU: r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        op_d     = op_q;

        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, opb_q});
        rem_sub = rem_sh[WIDTH-1:0] - opb_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d  = ALUControl;
                    opb_d = SrcB;
                    hi_d  = '0;
                    lo_d  = SrcA;
                    if (ALUControl == OP_MUL || ALUControl == OP_MULHU) begin
                        count_d = CNT_FULL;
                        state_d = S_MUL;
                    end else if ((ALUControl == OP_DIVU || ALUControl == OP_REMU)
                                 && SrcB != '0) begin
                        count_d = CNT_FULL;
                        state_d = S_DIV;
                    end else begin
                        result_d = single_op(ALUControl, SrcA, SrcB);
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                hi_d    = mul_sum[WIDTH:1];
                lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    result_d = (op_q == OP_MULHU) ? mul_sum[WIDTH:1]
                                                  : {mul_sum[0], lo_q[WIDTH-1:1]};
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DIV: begin
                hi_d    = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                lo_d    = {lo_q[WIDTH-2:0], rem_ge};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    result_d = (op_q == OP_REMU) ? (rem_ge ? rem_sub : rem_sh[WIDTH-1:0])
                                                 : {lo_q[WIDTH-2:0], rem_ge};
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Datapath working registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        opb_q <= opb_d;
        op_q  <= op_d;
    end

    assign ALUResult = result_q;
    assign Zero      = (result_q == '0);
    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;

endmodule
